branch_ctrl: RTL and testbench
==============================

BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  reset, asynchronous, active-high; one clock, no other clock or reset in the block.
REQ-003 req_valid  input  1  resolve request present.
REQ-004 req_ready  output  1  block can accept a request.
REQ-005 isBranch / isJal / isJalr  input  1 each  decoded control-transfer type, one-hot.
REQ-006 funct3  input  3  branch condition select.
REQ-007 pc, imm, rs1Data, rs2Data  input  32 each  instruction PC, sign-extended immediate, and source operands.
REQ-008 resp_valid  output  1  resolution result available.
REQ-009 resp_ready  input  1  consumer accepts the result.
REQ-010 taken  output  1  control transfer occurs.
REQ-011 redirect  output  1  equal to taken AND NOT misaligned AND NOT illegal; drives fetch flush and PC load.
REQ-012 target, link  output  32 each  redirect address, and pc+4.
REQ-013 misaligned, illegal  output  1 each  exception flags.
REQ-014 takenCount  output  16  saturating count of accepted redirects.

Function
REQ-015 The FSM SHALL have three states: IDLE, EVAL and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE.
REQ-017 In IDLE, when req_valid=1, the block SHALL register all request inputs and move to EVAL at the same edge.
REQ-018 EVAL SHALL last exactly one cycle, compute the result into registers, and move to RESP.
REQ-019 In RESP, resp_valid SHALL be 1 and all result outputs SHALL stay stable until the cycle with resp_ready=1; the block SHALL then return to IDLE.
REQ-020 Minimum latency SHALL be 2 cycles (accept edge to first resp_valid=1 cycle) and minimum throughput one request per 3 cycles.
REQ-021 Comparison SHALL use diff = rs1 + ~rs2 + 1 on 32 bits.
  - eq = (diff==0).
  - lt (signed) = (rs1[31] & ~rs2[31]) | ((rs1[31] ~^ rs2[31]) & diff[31]).
  - ltu = (~rs1[31] & rs2[31]) | ((rs1[31] ~^ rs2[31]) & diff[31]).
REQ-022 Branch taken by funct3:
  - 000 = eq, 001 = ~eq
  - 100 = lt, 101 = ~lt
  - 110 = ltu, 111 = ~ltu
  - 010 and 011: taken=0, illegal=1.
REQ-023 isJal and isJalr SHALL force taken=1 with funct3 ignored.
REQ-024 Target computation:
  - isBranch or isJal: target = pc+imm.
  - isJalr: target = (rs1+imm) with bit0 cleared.
  - All additions mod 2^32; wrap-around is not flagged.
REQ-025 link SHALL be pc+4 mod 2^32 for every request.
REQ-026 misaligned SHALL be taken AND target[1:0]!=0; when taken=0, misaligned=0.
REQ-027 If the type inputs are not exactly one-hot (zero or multiple set), the result SHALL be taken=0, illegal=1, target=pc+4.
REQ-028 On the RESP handshake cycle with redirect=1, takenCount SHALL increment by 1, saturating at 0xFFFF.
REQ-029 req_valid seen outside IDLE SHALL be ignored; only req_ready=1 accepts a request.
REQ-030 The registered request SHALL not be changed by input changes in EVAL or RESP.

Reset
REQ-031 While rst=1 the block SHALL immediately be in:
  - FSM state IDLE;
  - req_ready=1, resp_valid=0;
  - taken=0, redirect=0, misaligned=0, illegal=0;
  - target=0, link=0, takenCount=0.
REQ-032 rst asserted in EVAL or RESP SHALL drop the in-flight request with no response and no counter change; the first accept after rst falls SHALL be processed normally.

Verification
REQ-033 beq: pc=0x100, imm=0x20, rs1=rs2=5 -> resp_valid 2 cycles after accept; taken=1, redirect=1, target=0x120, link=0x104, takenCount=1.
REQ-034 Signed/unsigned split: rs1=0xFFFFFFFF, rs2=1:
  - blt -> taken=1;
  - bltu -> taken=0, redirect=0, takenCount unchanged.
REQ-035 jalr: rs1=0x1001, imm=2 -> target=0x1002, misaligned=1, redirect=0. Same request with imm=3 -> target=0x1004, misaligned=0, redirect=1.
REQ-036 Backpressure: hold resp_ready=0 for 5 cycles in RESP while driving a new req_valid=1 with different operands:
  - outputs stable, req_ready=0;
  - the new request is accepted only after the handshake.
REQ-037 Illegal cases: funct3=010 with isBranch=1 -> illegal=1, taken=0. isJal=isJalr=1 -> illegal=1, target=pc+4.
REQ-038 Reset mid-operation: pulse rst during EVAL -> resp_valid never asserts, req_ready=1 immediately. Separately, preload takenCount=0xFFFF, then one more redirect -> takenCount stays 0xFFFF.

Source files
------------

// File: rtl/branch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : branch_ctrl
//  Description : Control-transfer resolution unit. Accepts one branch / jal /
//                jalr resolve request at a time through a valid/ready
//                handshake, evaluates the condition and target in a single
//                EVAL cycle, and presents a registered result that is held
//                until the consumer accepts it. Also keeps a saturating count
//                of redirects that were handed to the consumer.
//
//  Ports
//    clk          : rising-edge clock for all state
//    rst          : asynchronous active-high reset
//    req_valid    : resolve request present
//    req_ready    : block can accept a request (IDLE only)
//    isBranch     : request is a conditional branch (types expected one-hot)
//    isJal        : request is a jal
//    isJalr       : request is a jalr
//    funct3       : branch condition select
//    pc           : instruction PC
//    imm          : sign-extended immediate
//    rs1Data      : source operand 1
//    rs2Data      : source operand 2
//    resp_valid   : result available (RESP only)
//    resp_ready   : consumer accepts the result
//    taken        : control transfer occurs
//    redirect     : taken and neither misaligned nor illegal
//    target       : redirect address
//    link         : pc + 4
//    misaligned   : taken with target[1:0] != 0
//    illegal      : unsupported funct3 or non-one-hot type
//    takenCount   : saturating count of accepted redirects
//
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        isBranch,
    input  logic        isJal,
    input  logic        isJalr,
    input  logic [2:0]  funct3,
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic [31:0] rs1Data,
    input  logic [31:0] rs2Data,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        taken,
    output logic        redirect,
    output logic [31:0] target,
    output logic [31:0] link,
    output logic        misaligned,
    output logic        illegal,
    output logic [15:0] takenCount
);

    // ------------------------------------------------------------------------
    // Constants and state encoding
    // ------------------------------------------------------------------------
    localparam logic [15:0] c_count_max = 16'hFFFF;
    localparam logic [31:0] c_four      = 32'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t r_state;

    // ------------------------------------------------------------------------
    // Registered request (captured only on the accept edge)
    // ------------------------------------------------------------------------
    logic        r_is_branch;
    logic        r_is_jal;
    logic        r_is_jalr;
    logic [2:0]  r_funct3;
    logic [31:0] r_pc;
    logic [31:0] r_imm;
    logic [31:0] r_rs1;
    logic [31:0] r_rs2;

    // ------------------------------------------------------------------------
    // Registered result / handshake outputs
    // ------------------------------------------------------------------------
    logic        r_req_ready;
    logic        r_resp_valid;
    logic        r_taken;
    logic        r_redirect;
    logic [31:0] r_target;
    logic [31:0] r_link;
    logic        r_misaligned;
    logic        r_illegal;
    logic [15:0] r_taken_count;

    // ------------------------------------------------------------------------
    // Combinational evaluation of the registered request. Only consumed in
    // EVAL, so it is never affected by live input changes.
    // ------------------------------------------------------------------------
    logic [31:0] w_diff;
    logic        w_eq;
    logic        w_lt;
    logic        w_ltu;
    logic        w_sign_same;
    logic [1:0]  w_type_cnt;
    logic        w_one_hot;
    logic [31:0] w_pc_imm;
    logic [31:0] w_rs1_imm;
    logic [31:0] w_pc_plus4;
    logic        w_taken;
    logic        w_illegal;
    logic [31:0] w_target;
    logic        w_misaligned;
    logic        w_redirect;

    // One subtractor serves both signed and unsigned compares: when the sign
    // bits differ the answer follows directly from them, otherwise the
    // difference cannot overflow and its sign bit decides.
    assign w_diff      = r_rs1 + ~r_rs2 + 32'd1;
    assign w_eq        = (w_diff == 32'd0);
    assign w_sign_same = ~(r_rs1[31] ^ r_rs2[31]);
    assign w_lt        = (r_rs1[31] & ~r_rs2[31]) | (w_sign_same & w_diff[31]);
    assign w_ltu       = (~r_rs1[31] & r_rs2[31]) | (w_sign_same & w_diff[31]);

    assign w_type_cnt  = {1'b0, r_is_branch} + {1'b0, r_is_jal} + {1'b0, r_is_jalr};
    assign w_one_hot   = (w_type_cnt == 2'd1);

    assign w_pc_imm    = r_pc + r_imm;
    assign w_rs1_imm   = r_rs1 + r_imm;
    assign w_pc_plus4  = r_pc + c_four;

    always_comb begin
        w_taken   = 1'b0;
        w_illegal = 1'b0;
        w_target  = w_pc_imm;

        if (!w_one_hot) begin
            // Ambiguous or missing type: no transfer, fall through to pc+4.
            w_illegal = 1'b1;
            w_target  = w_pc_plus4;
        end else if (r_is_jal) begin
            w_taken   = 1'b1;
        end else if (r_is_jalr) begin
            w_taken   = 1'b1;
            w_target  = {w_rs1_imm[31:1], 1'b0};
        end else begin
            case (r_funct3)
                3'b000:  w_taken = w_eq;
                3'b001:  w_taken = ~w_eq;
                3'b100:  w_taken = w_lt;
                3'b101:  w_taken = ~w_lt;
                3'b110:  w_taken = w_ltu;
                3'b111:  w_taken = ~w_ltu;
                default: w_illegal = 1'b1;
            endcase
        end
    end

    assign w_misaligned = w_taken & (w_target[1:0] != 2'b00);
    assign w_redirect   = w_taken & ~w_misaligned & ~w_illegal;

    // ------------------------------------------------------------------------
    // FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_req_ready   <= 1'b1;
            r_resp_valid  <= 1'b0;
            r_is_branch   <= 1'b0;
            r_is_jal      <= 1'b0;
            r_is_jalr     <= 1'b0;
            r_funct3      <= 3'd0;
            r_pc          <= 32'd0;
            r_imm         <= 32'd0;
            r_rs1         <= 32'd0;
            r_rs2         <= 32'd0;
            r_taken       <= 1'b0;
            r_redirect    <= 1'b0;
            r_target      <= 32'd0;
            r_link        <= 32'd0;
            r_misaligned  <= 1'b0;
            r_illegal     <= 1'b0;
            r_taken_count <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_is_branch <= isBranch;
                        r_is_jal    <= isJal;
                        r_is_jalr   <= isJalr;
                        r_funct3    <= funct3;
                        r_pc        <= pc;
                        r_imm       <= imm;
                        r_rs1       <= rs1Data;
                        r_rs2       <= rs2Data;
                        r_req_ready <= 1'b0;
                        r_state     <= S_EVAL;
                    end
                end

                S_EVAL: begin
                    r_taken      <= w_taken;
                    r_redirect   <= w_redirect;
                    r_target     <= w_target;
                    r_link       <= w_pc_plus4;
                    r_misaligned <= w_misaligned;
                    r_illegal    <= w_illegal;
                    r_resp_valid <= 1'b1;
                    r_state      <= S_RESP;
                end

                S_RESP: begin
                    // Results are held; only the handshake moves things on.
                    if (resp_ready) begin
                        if (r_redirect && (r_taken_count != c_count_max)) begin
                            r_taken_count <= r_taken_count + 16'd1;
                        end
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end

                default: begin
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------------
    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign taken      = r_taken;
    assign redirect   = r_redirect;
    assign target     = r_target;
    assign link       = r_link;
    assign misaligned = r_misaligned;
    assign illegal    = r_illegal;
    assign takenCount = r_taken_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_ctrl
//  Description : Self-checking bench for branch_ctrl. Directed cases for the
//                documented scenarios followed by randomized requests, all
//                compared against a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        isBranch;
    logic        isJal;
    logic        isJalr;
    logic [2:0]  funct3;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1Data;
    logic [31:0] rs2Data;
    logic        resp_valid;
    logic        resp_ready;
    logic        taken;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] link;
    logic        misaligned;
    logic        illegal;
    logic [15:0] takenCount;

    int          r_errors = 0;
    int          r_checks = 0;
    logic [15:0] r_model_count = 16'd0;

    branch_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .isBranch   (isBranch),
        .isJal      (isJal),
        .isJalr     (isJalr),
        .funct3     (funct3),
        .pc         (pc),
        .imm        (imm),
        .rs1Data    (rs1Data),
        .rs2Data    (rs2Data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .taken      (taken),
        .redirect   (redirect),
        .target     (target),
        .link       (link),
        .misaligned (misaligned),
        .illegal    (illegal),
        .takenCount (takenCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        r_checks++;
        if (act !== exp) begin
            r_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Reference: architectural meaning of each control-transfer type.
    task automatic model(input logic b, input logic j, input logic jr, input logic [2:0] f3,
                         input logic [31:0] a_pc, input logic [31:0] a_imm,
                         input logic [31:0] a_rs1, input logic [31:0] a_rs2,
                         output logic tk, output logic rd, output logic mis,
                         output logic ill, output logic [31:0] tgt, output logic [31:0] lnk);
        int n;
        n   = int'(b) + int'(j) + int'(jr);
        lnk = a_pc + 32'd4;
        ill = 1'b0;
        tk  = 1'b0;
        tgt = a_pc + a_imm;
        if (n != 1) begin
            ill = 1'b1;
            tgt = a_pc + 32'd4;
        end else if (j) begin
            tk = 1'b1;
        end else if (jr) begin
            tk  = 1'b1;
            tgt = (a_rs1 + a_imm) & 32'hFFFF_FFFE;
        end else begin
            case (f3)
                3'd0:    tk = (a_rs1 == a_rs2);
                3'd1:    tk = (a_rs1 != a_rs2);
                3'd4:    tk = ($signed(a_rs1) <  $signed(a_rs2));
                3'd5:    tk = ($signed(a_rs1) >= $signed(a_rs2));
                3'd6:    tk = (a_rs1 <  a_rs2);
                3'd7:    tk = (a_rs1 >= a_rs2);
                default: ill = 1'b1;
            endcase
        end
        mis = tk && (tgt[1:0] != 2'b00);
        rd  = tk && !mis && !ill;
    endtask

    task automatic drive_garbage();
        isBranch = 1'($urandom);
        isJal    = 1'($urandom);
        isJalr   = 1'($urandom);
        funct3   = 3'($urandom);
        pc       = $urandom;
        imm      = $urandom;
        rs1Data  = $urandom;
        rs2Data  = $urandom;
    endtask

    // One full transaction. Called at posedge+1 with the block in IDLE.
    // While the block is busy req_valid stays high with unrelated operands,
    // which must be ignored.
    task automatic run_txn(input logic b, input logic j, input logic jr, input logic [2:0] f3,
                           input logic [31:0] a_pc, input logic [31:0] a_imm,
                           input logic [31:0] a_rs1, input logic [31:0] a_rs2,
                           input int stall);
        logic        e_tk, e_rd, e_mis, e_ill;
        logic [31:0] e_tgt, e_lnk;
        model(b, j, jr, f3, a_pc, a_imm, a_rs1, a_rs2, e_tk, e_rd, e_mis, e_ill, e_tgt, e_lnk);

        check("idle_req_ready", 32'(req_ready), 32'd1);
        isBranch = b;  isJal = j;  isJalr = jr;  funct3 = f3;
        pc = a_pc;  imm = a_imm;  rs1Data = a_rs1;  rs2Data = a_rs2;
        req_valid  = 1'b1;
        resp_ready = 1'b0;
        @(posedge clk); #1;
        drive_garbage();
        check("eval_req_ready", 32'(req_ready), 32'd0);
        check("eval_resp_valid", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        for (int s = 0; s <= stall; s++) begin
            check("resp_valid", 32'(resp_valid), 32'd1);
            check("resp_req_ready", 32'(req_ready), 32'd0);
            check("taken", 32'(taken), 32'(e_tk));
            check("redirect", 32'(redirect), 32'(e_rd));
            check("misaligned", 32'(misaligned), 32'(e_mis));
            check("illegal", 32'(illegal), 32'(e_ill));
            check("target", target, e_tgt);
            check("link", link, e_lnk);
            check("count_hold", 32'(takenCount), 32'(r_model_count));
            if (s == stall) resp_ready = 1'b1;
            else drive_garbage();
            @(posedge clk); #1;
        end
        if (e_rd && r_model_count != 16'hFFFF) r_model_count = r_model_count + 16'd1;
        resp_ready = 1'b0;
        check("post_resp_valid", 32'(resp_valid), 32'd0);
        check("post_req_ready", 32'(req_ready), 32'd1);
        check("takenCount", 32'(takenCount), 32'(r_model_count));
        req_valid = 1'b0;
    endtask

    logic [2:0]  r_sel;
    logic [2:0]  r_type;
    logic [31:0] r_a;
    logic [31:0] r_b;

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        isBranch   = 1'b0;  isJal = 1'b0;  isJalr = 1'b0;
        funct3     = 3'd0;
        pc = 32'd0;  imm = 32'd0;  rs1Data = 32'd0;  rs2Data = 32'd0;
        #2;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_flags", {28'd0, taken, redirect, misaligned, illegal}, 32'd0);
        check("rst_target", target, 32'd0);
        check("rst_link", link, 32'd0);
        check("rst_count", 32'(takenCount), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;

        // beq taken, count 0 -> 1
        run_txn(1, 0, 0, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 0);
        // signed vs unsigned split
        run_txn(1, 0, 0, 3'b100, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 0);
        run_txn(1, 0, 0, 3'b110, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 0);
        // jalr misaligned then aligned
        run_txn(0, 0, 1, 3'b000, 32'h300, 32'd2, 32'h1001, 32'd0, 0);
        run_txn(0, 0, 1, 3'b000, 32'h300, 32'd3, 32'h1001, 32'd0, 0);
        // backpressure: 5 stalled cycles with live req_valid
        run_txn(0, 1, 0, 3'b010, 32'h400, 32'h80, 32'd7, 32'd9, 5);
        // illegal funct3 and non-one-hot type
        run_txn(1, 0, 0, 3'b010, 32'h500, 32'h10, 32'd1, 32'd1, 0);
        run_txn(0, 1, 1, 3'b000, 32'h600, 32'h10, 32'd1, 32'd1, 0);
        run_txn(0, 0, 0, 3'b000, 32'hFFFF_FFFC, 32'h10, 32'd1, 32'd1, 0);

        // Reset during EVAL drops the request.
        isBranch = 1'b1;  isJal = 1'b0;  isJalr = 1'b0;  funct3 = 3'b000;
        pc = 32'h700;  imm = 32'h8;  rs1Data = 32'd3;  rs2Data = 32'd3;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("pre_rst_eval_ready", 32'(req_ready), 32'd0);
        rst = 1'b1;
        #1;
        r_model_count = 16'd0;
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        check("midrst_resp_valid", 32'(resp_valid), 32'd0);
        check("midrst_count", 32'(takenCount), 32'd0);
        #2 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("after_rst_no_resp", 32'(resp_valid), 32'd0);
        end
        run_txn(1, 0, 0, 3'b001, 32'h800, 32'hC, 32'd3, 32'd4, 1);

        // Saturation: preload the counter then one more redirect.
        force dut.r_taken_count = 16'hFFFF;
        #1;
        release dut.r_taken_count;
        r_model_count = 16'hFFFF;
        check("preload_count", 32'(takenCount), 32'h0000_FFFF);
        run_txn(0, 1, 0, 3'b000, 32'h900, 32'h100, 32'd0, 32'd0, 0);
        r_model_count = 16'd0;
        rst = 1'b1;
        #2 rst = 1'b0;
        @(posedge clk); #1;

        // Randomized requests.
        for (int t = 0; t < 60; t++) begin
            r_sel = 3'($urandom_range(0, 7));
            case (r_sel)
                3'd0:    r_type = 3'($urandom);
                3'd1,
                3'd2:    r_type = 3'b010;
                3'd3:    r_type = 3'b001;
                default: r_type = 3'b100;
            endcase
            r_a = $urandom;
            case ($urandom_range(0, 3))
                0:       r_b = r_a;
                1:       r_b = {~r_a[31], r_a[30:0]};
                default: r_b = $urandom;
            endcase
            run_txn(r_type[2], r_type[1], r_type[0], 3'($urandom), $urandom,
                    ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 64)) : $urandom,
                    r_a, r_b, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", r_errors, r_checks);
        $finish;
    end

endmodule
`default_nettype wire
